// File: rtl/addsub_flag_defs.sv
// Shared flag-vector layout and condition-code encodings for the add/sub flag path.
package addsub_flag_defs;

   localparam int FLAG_W = 5;

   localparam int FLAG_CF = 0;
   localparam int FLAG_OF = 1;
   localparam int FLAG_ZF = 2;
   localparam int FLAG_SF = 3;
   localparam int FLAG_PF = 4;

   localparam logic [3:0] COND_O  = 4'h0;
   localparam logic [3:0] COND_NO = 4'h1;
   localparam logic [3:0] COND_B  = 4'h2;
   localparam logic [3:0] COND_NB = 4'h3;
   localparam logic [3:0] COND_E  = 4'h4;
   localparam logic [3:0] COND_NE = 4'h5;
   localparam logic [3:0] COND_BE = 4'h6;
   localparam logic [3:0] COND_A  = 4'h7;
   localparam logic [3:0] COND_S  = 4'h8;
   localparam logic [3:0] COND_NS = 4'h9;
   localparam logic [3:0] COND_P  = 4'hA;
   localparam logic [3:0] COND_NP = 4'hB;
   localparam logic [3:0] COND_L  = 4'hC;
   localparam logic [3:0] COND_GE = 4'hD;
   localparam logic [3:0] COND_LE = 4'hE;
   localparam logic [3:0] COND_G  = 4'hF;

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against a {PF,SF,ZF,OF,CF} vector.
module flag_cond_eval
   import addsub_flag_defs::*;
(
   input  logic [3:0]        cond_i,
   input  logic [FLAG_W-1:0] flags_i,
   output logic              true_o
);

   logic cf_s, of_s, zf_s, sf_s, pf_s;

   assign cf_s = flags_i[FLAG_CF];
   assign of_s = flags_i[FLAG_OF];
   assign zf_s = flags_i[FLAG_ZF];
   assign sf_s = flags_i[FLAG_SF];
   assign pf_s = flags_i[FLAG_PF];

   // Condition decode; odd codes are the negation of the preceding even code.
   always_comb begin
      true_o = 1'b0;
      case (cond_i)
         COND_O:  true_o = of_s;
         COND_NO: true_o = ~of_s;
         COND_B:  true_o = cf_s;
         COND_NB: true_o = ~cf_s;
         COND_E:  true_o = zf_s;
         COND_NE: true_o = ~zf_s;
         COND_BE: true_o = cf_s | zf_s;
         COND_A:  true_o = ~(cf_s | zf_s);
         COND_S:  true_o = sf_s;
         COND_NS: true_o = ~sf_s;
         COND_P:  true_o = pf_s;
         COND_NP: true_o = ~pf_s;
         COND_L:  true_o = sf_s ^ of_s;
         COND_GE: true_o = ~(sf_s ^ of_s);
         COND_LE: true_o = zf_s | (sf_s ^ of_s);
         COND_G:  true_o = ~(zf_s | (sf_s ^ of_s));
         default: true_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/addsub_flag_stage.sv
// Output stage of the add/sub flag adder: flag register, condition evaluation, 2-entry skid.
// Optional saturating overflow counter enabled by defining ADDSUB_OVF_COUNT_EN.
module addsub_flag_stage
   import addsub_flag_defs::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_s,
   input  logic              in_cf,
   input  logic              in_of,
   input  logic              in_zf,
   input  logic              in_sf,
   input  logic              in_pf,
   input  logic              in_flag_we,
   input  logic [3:0]        in_cond,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_s,
   output logic [FLAG_W-1:0] out_flags,
   output logic              out_cond_true
`ifdef ADDSUB_OVF_COUNT_EN
   , input  logic             ovf_clr
   , output logic [CNT_W-1:0] ovf_count
`endif
);

   logic [FLAG_W-1:0] flag_q, flag_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_s_q, out_s_d;
   logic [FLAG_W-1:0] out_flags_q, out_flags_d;
   logic              out_cond_q, out_cond_d;
   logic              skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0]  skid_s_q, skid_s_d;
   logic [FLAG_W-1:0] skid_flags_q, skid_flags_d;
   logic              skid_cond_q, skid_cond_d;

   logic              accept_s;
   logic [FLAG_W-1:0] new_flags_s;
   logic              new_cond_s;

   assign accept_s    = in_valid & in_ready_q;
   assign new_flags_s = in_flag_we ? {in_pf, in_sf, in_zf, in_of, in_cf} : flag_q;

   flag_cond_eval u_cond (
      .cond_i  (in_cond),
      .flags_i (new_flags_s),
      .true_o  (new_cond_s)
   );

   // Next state for the flag register, output register and skid entry.
   always_comb begin
      flag_d       = flag_q;
      out_valid_d  = out_valid_q;
      out_s_d      = out_s_q;
      out_flags_d  = out_flags_q;
      out_cond_d   = out_cond_q;
      skid_valid_d = skid_valid_q;
      skid_s_d     = skid_s_q;
      skid_flags_d = skid_flags_q;
      skid_cond_d  = skid_cond_q;

      if (accept_s) begin
         flag_d = new_flags_s;
      end else begin
         flag_d = flag_q;
      end

      // in_ready is low whenever the skid is full, so a skid drain never races an accept.
      if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_s_d      = skid_s_q;
            out_flags_d  = skid_flags_q;
            out_cond_d   = skid_cond_q;
            skid_valid_d = 1'b0;
         end else if (accept_s) begin
            out_valid_d  = 1'b1;
            out_s_d      = in_s;
            out_flags_d  = new_flags_s;
            out_cond_d   = new_cond_s;
         end else begin
            out_valid_d  = 1'b0;
         end
      end else begin
         if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_s_d     = in_s;
            skid_flags_d = new_flags_s;
            skid_cond_d  = new_cond_s;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end

      in_ready_d = ~skid_valid_d;
   end

   // Stage state registers; reset discards every in-flight entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_q       <= '0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_s_q      <= '0;
         out_flags_q  <= '0;
         out_cond_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_s_q     <= '0;
         skid_flags_q <= '0;
         skid_cond_q  <= 1'b0;
      end else begin
         flag_q       <= flag_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_s_q      <= out_s_d;
         out_flags_q  <= out_flags_d;
         out_cond_q   <= out_cond_d;
         skid_valid_q <= skid_valid_d;
         skid_s_q     <= skid_s_d;
         skid_flags_q <= skid_flags_d;
         skid_cond_q  <= skid_cond_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = out_valid_q;
   assign out_s         = out_s_q;
   assign out_flags     = out_flags_q;
   assign out_cond_true = out_cond_q;

`ifdef ADDSUB_OVF_COUNT_EN
   logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

   // Saturating count of flag-writing overflow accepts; clear wins over increment.
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_clr) begin
         ovf_cnt_d = '0;
      end else if (accept_s && in_flag_we && in_of && (ovf_cnt_q != {CNT_W{1'b1}})) begin
         ovf_cnt_d = ovf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         ovf_cnt_d = ovf_cnt_q;
      end
   end

   // Overflow counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_cnt_q <= '0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_addsub_flag_stage.sv
// Scoreboard bench for addsub_flag_stage; the overflow counter is exercised when ADDSUB_OVF_COUNT_EN is defined.
module tb_addsub_flag_stage;

   localparam int W = 32;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_s;
   logic          in_cf, in_of, in_zf, in_sf, in_pf;
   logic          in_flag_we;
   logic [3:0]    in_cond;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_s;
   logic [4:0]    out_flags;
   logic          out_cond_true;
`ifdef ADDSUB_OVF_COUNT_EN
   logic          ovf_clr;
   logic [CW-1:0] ovf_count;
   int            m_cnt;
`endif

   typedef struct packed {
      logic [W-1:0] s;
      logic [4:0]   f;
      logic         c;
   } ent_t;

   ent_t       sb[$];
   logic [4:0] m_flags;
   int         n_chk;
   int         n_pass;

   addsub_flag_stage #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_s          (in_s),
      .in_cf         (in_cf),
      .in_of         (in_of),
      .in_zf         (in_zf),
      .in_sf         (in_sf),
      .in_pf         (in_pf),
      .in_flag_we    (in_flag_we),
      .in_cond       (in_cond),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_s         (out_s),
      .out_flags     (out_flags),
      .out_cond_true (out_cond_true)
`ifdef ADDSUB_OVF_COUNT_EN
      , .ovf_clr     (ovf_clr)
      , .ovf_count   (ovf_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference condition: pairs of codes share a base predicate, low bit inverts.
   function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
      logic cf, of, zf, sf, pf, base;
      {pf, sf, zf, of, cf} = f;
      case (c[3:1])
         3'd0: base = of;
         3'd1: base = cf;
         3'd2: base = zf;
         3'd3: base = cf | zf;
         3'd4: base = sf;
         3'd5: base = pf;
         3'd6: base = sf ^ of;
         3'd7: base = zf | (sf ^ of);
         default: base = 1'b0;
      endcase
      return base ^ c[0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drv(input logic v, input logic [W-1:0] s, input logic [4:0] f,
                      input logic we, input logic [3:0] c);
      in_valid   = v;
      in_s       = s;
      {in_pf, in_sf, in_zf, in_of, in_cf} = f;
      in_flag_we = we;
      in_cond    = c;
   endtask

   // One clock: score handshakes seen before the edge, then advance to edge+1.
   task automatic tick();
      ent_t       e;
      logic [4:0] nf;
      logic       acc, con, held;
      logic [W+6:0] prev;
      acc  = in_valid & in_ready;
      con  = out_valid & out_ready;
      held = out_valid & ~out_ready;
      prev = {out_valid, out_s, out_flags, out_cond_true};
      if (con) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            check("out_s", 64'(out_s), 64'(e.s));
            check("out_flags", 64'(out_flags), 64'(e.f));
            check("out_cond_true", 64'(out_cond_true), 64'(e.c));
         end
      end
      if (acc) begin
         nf = in_flag_we ? {in_pf, in_sf, in_zf, in_of, in_cf} : m_flags;
         m_flags = nf;
         sb.push_back('{s: in_s, f: nf, c: ref_cond(in_cond, nf)});
      end
`ifdef ADDSUB_OVF_COUNT_EN
      if (ovf_clr) m_cnt = 0;
      else if (acc && in_flag_we && in_of && m_cnt < 3) m_cnt++;
`endif
      @(posedge clk);
      #1;
      if (held) check("hold_stable", 64'({out_valid, out_s, out_flags, out_cond_true}), 64'(prev));
`ifdef ADDSUB_OVF_COUNT_EN
      check("ovf_count", 64'(ovf_count), 64'(m_cnt));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_pass = 0;
      m_flags = 5'b00000;
      rst = 1'b1;
      out_ready = 1'b0;
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
`ifdef ADDSUB_OVF_COUNT_EN
      ovf_clr = 1'b0;
      m_cnt = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_s", 64'(out_s), 64'd0);
      check("rst_out_flags", 64'(out_flags), 64'd0);
      check("rst_out_cond", 64'(out_cond_true), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      tick();
      check("ready_after_rst", 64'(in_ready), 64'd1);

      // Compare-equal and its negation
      out_ready = 1'b1;
      drv(1'b1, 32'h0, 5'b00100, 1'b1, 4'h4);
      tick();
      check("ce_valid", 64'(out_valid), 64'd1);
      check("ce_flags", 64'(out_flags), 64'h04);
      check("ce_true", 64'(out_cond_true), 64'd1);
      drv(1'b1, 32'h0, 5'b00100, 1'b1, 4'h5);
      tick();
      check("cne_true", 64'(out_cond_true), 64'd0);

      // Flag hold when the op does not write flags
      drv(1'b1, 32'h5, 5'b00001, 1'b1, 4'h2);
      tick();
      drv(1'b1, 32'h6, 5'b00000, 1'b0, 4'h2);
      tick();
      check("hold_flags", 64'(out_flags), 64'h01);
      check("hold_cond", 64'(out_cond_true), 64'd1);

      // Signed less-than / greater-or-equal
      drv(1'b1, 32'h7, 5'b01000, 1'b1, 4'hC);
      tick();
      check("lt_sf1_of0", 64'(out_cond_true), 64'd1);
      drv(1'b1, 32'h8, 5'b01010, 1'b1, 4'hC);
      tick();
      check("lt_sf1_of1", 64'(out_cond_true), 64'd0);
      drv(1'b1, 32'h9, 5'b01010, 1'b1, 4'hD);
      tick();
      check("ge_sf1_of1", 64'(out_cond_true), 64'd1);

      // Backpressure through the skid buffer
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
      tick();
      out_ready = 1'b0;
      drv(1'b1, 32'h11, 5'b00000, 1'b1, 4'h0);
      tick();
      drv(1'b1, 32'h22, 5'b00000, 1'b1, 4'h0);
      tick();
      check("bp_ready_low", 64'(in_ready), 64'd0);
      drv(1'b1, 32'h33, 5'b00000, 1'b1, 4'h0);
      tick();
      tick();
      check("bp_first_held", 64'(out_s), 64'h11);
      out_ready = 1'b1;
      tick();
      check("bp_second_s", 64'(out_s), 64'h22);
      check("bp_second_v", 64'(out_valid), 64'd1);
      tick();
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
      check("bp_third_s", 64'(out_s), 64'h33);
      tick();
      check("bp_drained", 64'(out_valid), 64'd0);

      // Random traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         drv(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 1'($urandom), 4'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef ADDSUB_OVF_COUNT_EN
         ovf_clr = ($urandom_range(0, 15) == 0);
`endif
         tick();
      end
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
      out_ready = 1'b1;
`ifdef ADDSUB_OVF_COUNT_EN
      ovf_clr = 1'b0;
`endif
      for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
      check("drain_empty", 64'(sb.size()), 64'd0);

      // Reset with two entries held
      out_ready = 1'b0;
      drv(1'b1, 32'hA1, 5'b11111, 1'b1, 4'h0);
      tick();
      drv(1'b1, 32'hA2, 5'b10101, 1'b1, 4'h0);
      tick();
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
      rst = 1'b1;
      sb.delete();
      m_flags = 5'b00000;
`ifdef ADDSUB_OVF_COUNT_EN
      m_cnt = 0;
`endif
      #1;
      check("mrst_valid", 64'(out_valid), 64'd0);
      check("mrst_flags", 64'(out_flags), 64'd0);
      tick();
      check("mrst_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      tick();
      check("mrst_ready_rel", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no_stale", 64'(out_valid), 64'd0);
      end
      // Flag register must have been cleared: a no-write op sees zero flags
      drv(1'b1, 32'hB0, 5'b11111, 1'b0, 4'h3);
      tick();
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
      check("mrst_flagreg", 64'(out_flags), 64'h00);
      tick();

`ifdef ADDSUB_OVF_COUNT_EN
      // Saturation and clear-priority of the overflow counter
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, W'(i), 5'b00010, 1'b1, 4'h0);
         tick();
      end
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
      tick();
      check("ovf_saturated", 64'(ovf_count), 64'd3);
      drv(1'b1, 32'h66, 5'b00010, 1'b1, 4'h0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      drv(1'b0, 32'h0, 5'b00000, 1'b0, 4'h0);
      check("ovf_clr_prio", 64'(ovf_count), 64'd0);
      tick();
`endif

      for (int i = 0; i < 5 && sb.size() != 0; i++) tick();
      check("final_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/addsub_flag_stage.md
Name: addsub_flag_stage

Overview:
- Pipeline stage directly downstream of the 32-bit add/sub flag adder.
- Registers the sum S together with CF/OF/ZF/SF/PF, holds an architectural flag register, and evaluates a 4-bit branch condition code against the flags.
- Uses a valid/ready handshake with a 2-entry skid buffer so the combinational adder output can be stalled without loss.
- Feeds writeback and branch-resolve logic.

Parameters:
- WIDTH, 32, data width of the sum path.
- CNT_W, 8, width of the overflow event counter (used only with OVF_COUNT_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept.
- in_s  in  WIDTH  sum/difference from the adder.
- in_cf, in_of, in_zf, in_sf, in_pf  in  1 each  adder flags.
- in_flag_we  in  1  this op updates the flag register.
- in_cond  in  4  condition code to evaluate for this op.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_s  out  WIDTH  registered sum.
- out_flags  out  5  flag state after this op, packed {PF,SF,ZF,OF,CF}.
- out_cond_true  out  1  in_cond evaluated on out_flags.
- ovf_clr  in  1  synchronous counter clear (OVF_COUNT_EN only).
- ovf_count  out  CNT_W  saturating overflow count (OVF_COUNT_EN only).

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst is asynchronous and active-high.
- Reset state:
  - out_valid=0, out_s=0, out_flags=0, out_cond_true=0.
  - Flag register = 5'b00000.
  - Skid entry empty.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after deassertion.
- Accept: in_valid & in_ready.
  - If in_flag_we=1, new_flags = {in_pf,in_sf,in_zf,in_of,in_cf}; otherwise new_flags = the current flag register.
  - The flag register is updated to new_flags on the same edge, so flag order equals accept order.
  - The entry carries in_s, new_flags and cond_true(in_cond, new_flags).
- Latency: 1 cycle, accept to out_valid.
  - Throughput is 1 entry/cycle while out_ready=1.
- Skid buffer:
  - Main output register plus one skid register.
  - in_ready is registered and equals "skid empty".
  - If the output is held (out_valid & ~out_ready) and an accept occurs, the entry goes to the skid and in_ready drops next cycle.
  - When the output is consumed, the skid moves to output and in_ready rises next cycle.
  - Simultaneous consume and accept with skid empty: the new entry goes directly to output.
  - Output fields are stable while out_valid & ~out_ready.
  - No entry is ever dropped or duplicated.
- Condition codes, F = {PF,SF,ZF,OF,CF}:
  - 0 OF
  - 1 ~OF
  - 2 CF
  - 3 ~CF
  - 4 ZF
  - 5 ~ZF
  - 6 CF|ZF
  - 7 ~(CF|ZF)
  - 8 SF
  - 9 ~SF
  - A PF
  - B ~PF
  - C SF^OF
  - D ~(SF^OF)
  - E ZF|(SF^OF)
  - F ~(ZF|(SF^OF))
- CF semantics are as delivered upstream: borrow on subtract. PF is the XOR of all sum bits, used as-is.
- Reset mid-operation: all entries are discarded, with no partial output.
- Ready/valid rule: out_valid must not depend combinationally on out_ready.

Optional Feature:
- Macro: ADDSUB_OVF_COUNT_EN.
- When defined:
  - ovf_clr and ovf_count exist.
  - The counter increments on each accept with in_flag_we & in_of, saturating at all-ones.
  - ovf_clr has priority over increment.
  - The counter resets to 0.
- When undefined: the ports and the counter logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Package/header addsub_flag_defs:
  - Flag bit indices: CF=0, OF=1, ZF=2, SF=3, PF=4.
  - 4-bit condition-code constants COND_O through COND_G.
  - Flag vector width of 5.
- Sub-module flag_cond_eval: combinational, inputs cond[3:0] and flags[4:0], output true.
  - Reused by the branch unit.
- The skid buffer stays inline.

Test Plan:
- Reset: assert rst mid-stream with 2 entries held -> next cycle out_valid=0, out_flags=0; after release in_ready=1 and no stale entry appears.
- Compare equal: in_s=0, in_zf=1, others 0, in_flag_we=1, in_cond=4 -> one cycle later out_valid=1, out_flags=5'b00100, out_cond_true=1; with in_cond=5 -> 0.
- Flag hold: op1 sets CF=1 (flag_we=1); op2 has flag_we=0, in_cf=0, in_cond=2 -> op2 out_flags=5'b00001, out_cond_true=1.
- Backpressure: out_ready=0, push 0x11, 0x22 -> in_ready=0 after the second accept; release -> outputs 0x11 then 0x22 on consecutive cycles, none lost.
- Signed less: SF=1, OF=0, cond C -> true; SF=1, OF=1, cond C -> false, cond D -> true.
- ADDSUB_OVF_COUNT_EN with CNT_W=2: 5 accepts with in_of=1, flag_we=1 -> ovf_count=3 (saturated); pulse ovf_clr together with a 6th overflow accept -> 0.
